// File: rtl/bitmap_wnd_wr.sv
// Sliding-window bitmap: single-bit set/clear writes, a chunked scan that
// counts contiguous ones from bit 0, and an optional slide that shifts the
// counted ones out of the window once the scan finishes.
module bitmap_wnd_wr #(
  parameter int VECT_WIDTH     = 64,
  parameter int VECT_IND_WIDTH = 6,
  parameter int SCAN_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_val_in,
  input  logic [VECT_IND_WIDTH-1:0] set_ind_in,
  input  logic                      clr_val_in,
  input  logic [VECT_IND_WIDTH-1:0] clr_ind_in,
  input  logic                      scan_req_in,
  input  logic                      slide_in,
  output logic                      req_rdy_out,
  output logic [VECT_WIDTH-1:0]     vect_out,
  output logic                      run_val_out,
  output logic [VECT_IND_WIDTH:0]   run_len_out
);

  localparam int NCHUNK = VECT_WIDTH / SCAN_WIDTH;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = VECT_IND_WIDTH + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [VECT_WIDTH-1:0] vect, vect_nxt;
  logic [KW-1:0]         k, k_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  slide, slide_nxt;
  logic                  run_val, run_val_nxt;
  logic [CW-1:0]         run_len, run_len_nxt;
  logic [SCAN_WIDTH-1:0] chunk;
  logic [CW-1:0]         tail_ones;
  logic                  tail_run;

  // Select the chunk under the scan pointer.
  always_comb begin
    chunk = vect[int'(k)*SCAN_WIDTH +: SCAN_WIDTH];
  end

  // Count trailing ones of the current chunk (equals SCAN_WIDTH when full).
  always_comb begin
    tail_ones = '0;
    tail_run  = 1'b1;
    for (int i = 0; i < SCAN_WIDTH; i++) begin
      if (tail_run && chunk[i]) begin
        tail_ones = tail_ones + CW'(1);
      end else begin
        tail_run = 1'b0;
      end
    end
  end

  // Next-state logic for the FSM, bitmap, scan pointer and result.
  always_comb begin
    state_nxt   = state;
    vect_nxt    = vect;
    k_nxt       = k;
    cnt_nxt     = cnt;
    slide_nxt   = slide;
    run_val_nxt = 1'b0;
    run_len_nxt = run_len;
    case (state)
      IDLE: begin
        // Clear first so a same-index set wins.
        if (clr_val_in && (int'(clr_ind_in) < VECT_WIDTH)) begin
          vect_nxt[clr_ind_in] = 1'b0;
        end
        if (set_val_in && (int'(set_ind_in) < VECT_WIDTH)) begin
          vect_nxt[set_ind_in] = 1'b1;
        end
        if (scan_req_in) begin
          slide_nxt = slide_in;
          k_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        cnt_nxt = cnt + tail_ones;
        if ((&chunk) && (k != KW'(NCHUNK - 1))) begin
          k_nxt = k + KW'(1);
        end else begin
          // Partial chunk or last full chunk: the run ends here.
          state_nxt   = DONE;
          run_val_nxt = 1'b1;
          run_len_nxt = cnt + tail_ones;
        end
      end
      DONE: begin
        if (slide) begin
          vect_nxt = vect >> cnt;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      vect    <= '0;
      k       <= '0;
      cnt     <= '0;
      slide   <= 1'b0;
      run_val <= 1'b0;
      run_len <= '0;
    end else begin
      state   <= state_nxt;
      vect    <= vect_nxt;
      k       <= k_nxt;
      cnt     <= cnt_nxt;
      slide   <= slide_nxt;
      run_val <= run_val_nxt;
      run_len <= run_len_nxt;
    end
  end

  assign req_rdy_out = (state == IDLE);
  assign vect_out    = vect;
  assign run_val_out = run_val;
  assign run_len_out = run_len;

endmodule
